int_seq: RTL
============

# int_seq

Interrupt and reset sequencer for the 6502 core. It arbitrates between reset, NMI, IRQ and BRK. At an instruction boundary it forces a BRK opcode into the instruction register, then steps through the 7-cycle stack-push / vector-fetch sequence. It sits beside `decode` and the T-state machine and drives stack-push sources, vector addresses and the I-flag set.

## Interface
Parameters:
- `VEC_NMI`, 16'hFFFA, NMI vector low-byte address
- `VEC_RST`, 16'hFFFC, reset vector low-byte address
- `VEC_IRQ`, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- `i_clk`  in  1  core clock
- `i_rst_n`  in  1  reset; asynchronous, active-low
- `i_rdy`  in  1  advance enable; 0 freezes all state
- `i_sync`  in  1  opcode-fetch cycle (instruction boundary)
- `i_brk`  in  1  opcode being fetched is BRK ($00)
- `i_nmi_n`  in  1  NMI pin, asynchronous, falling-edge sensitive
- `i_irq_n`  in  1  IRQ pin, asynchronous, level-sensitive
- `i_pstatus`  in  8  processor status; bit 2 = I
- `o_inject`  out  1  replace the fetched opcode with $00 this cycle
- `o_seq_active`  out  1  sequence in progress; the T-state machine yields
- `o_push`  out  1  stack cycle: drive SP to the address bus, SP decrements
- `o_push_wr`  out  1  stack cycle is a write (0 during the reset sequence)
- `o_push_src`  out  2  0=PCH, 1=PCL, 2=P
- `o_push_b`  out  1  B-flag value for the pushed P
- `o_vec_rd`  out  1  vector read cycle
- `o_vec_addr`  out  16  vector byte address
- `o_set_i`  out  1  set the I flag
- `o_done`  out  1  one-cycle pulse on the final vector cycle

## Operation
- Synchronizers: `i_nmi_n` and `i_irq_n` each pass through a 2-FF synchronizer. Both reset to 1.
- NMI latch:
  - A synchronized 1→0 transition sets `nmi_pend`.
  - `nmi_pend` clears when the NMI vector is latched.
  - If a new edge arrives in the same cycle as the clear, the set wins.
- IRQ request: `irq_req = !irq_sync && !i_pstatus[2]`. It is combinational and not latched.
- Kinds and priority: RST > NMI > IRQ > BRK. The sequence kind is registered at entry.
- Entry from `S_IDLE` on `i_sync && i_rdy`:
  - If `nmi_pend || irq_req`: `o_inject=1`, kind = NMI or IRQ, go to `S_T2`. A concurrent `i_brk` is discarded.
  - Else if `i_brk`: kind = BRK, go to `S_T2`, `o_inject=0`.
- States, all Moore outputs; each advances one step per `i_rdy` cycle:
  - `S_T2`: dummy operand read; only `o_seq_active` is asserted.
  - `S_PCH`: `o_push=1`, `o_push_src=0`.
  - `S_PCL`: `o_push=1`, `o_push_src=1`.
  - `S_P`: `o_push=1`, `o_push_src=2`, `o_push_b = (kind==BRK)`. The vector base is latched at the end of this cycle.
  - `S_VECL`: `o_vec_rd=1`, `o_vec_addr=base`.
  - `S_VECH`: `o_vec_rd=1`, `o_vec_addr=base+1`, `o_set_i=1`, `o_done=1`. Next state is `S_IDLE`.
- `o_push_wr` equals `o_push`, except it is 0 whenever kind==RST.
- Vector base selection at `S_P`:
  - RST → `VEC_RST`.
  - Else `nmi_pend` → `VEC_NMI`, and `nmi_pend` is cleared.
  - Else → `VEC_IRQ`.
- `o_seq_active` is 1 in every state except `S_IDLE`.

## Timing
- Reset values:
  - State `S_T2`, kind RST, `nmi_pend=0`.
  - `o_seq_active=1`.
  - All other outputs 0, `o_vec_addr=0`.
- After reset release, the reset sequence runs with no `i_sync`. `o_done` falls on the 6th `i_rdy` cycle after release.
- `o_inject` is combinational in the `i_sync` cycle. `S_T2` follows on the next edge.
- Latency from entry to `o_done`: 6 `i_rdy` cycles.
- `i_rdy=0`: state, kind and latched vector hold. The NMI latch and synchronizers keep running.
- IRQ deasserted before `i_sync`: not serviced.
- IRQ masked by I=1: ignored.
- Asserting reset mid-sequence aborts immediately to the reset state. A pending NMI is lost.

## Configuration
- `INT_NMI_HIJACK_EN` defined:
  - An NMI that becomes pending at any point up to and including `S_P` of an IRQ/BRK sequence takes over the vector (`VEC_NMI`).
  - `o_push_b` keeps the BRK value.
- Undefined: the vector base is fixed at entry from the kind. NMI edges during the sequence stay pending for the next boundary.

## Test plan
- Release reset with `i_rdy=1`:
  - `o_push` high for 3 cycles with `o_push_wr=0`.
  - `o_vec_addr` = FFFC then FFFD.
  - `o_done` on cycle 6, then `o_seq_active=0`.
- `i_irq_n=0`, I=0, `i_sync` pulse:
  - `o_inject=1`.
  - Push sources 0,1,2 with `o_push_b=0`.
  - Vector FFFE/FFFF, `o_set_i=1`.
- `i_irq_n=0`, I=1, `i_sync`: `o_inject=0`, state stays `S_IDLE`.
- `i_brk=1` at `i_sync`, with an NMI edge during `S_PCL`:
  - Macro defined: vector FFFA, `o_push_b=1`.
  - Macro undefined: vector FFFE, and `nmi_pend` remains 1 afterwards.
- NMI falling edge held low for 20 cycles: exactly one sequence, vector FFFA. A second falling edge produces a second sequence.
- `i_rdy=0` for 3 cycles during `S_P`: outputs frozen, then the sequence completes normally. Total of 9 cycles.

Source files
------------

// File: rtl/int_seq.sv
// rtl/int_seq.sv - 6502 interrupt/reset sequencer: BRK injection, stack push and vector fetch
// Optional feature macro: INT_NMI_HIJACK_EN (late NMI takes over an IRQ/BRK vector)
module int_seq #(
   parameter logic [15:0] VEC_NMI = 16'hFFFA,
   parameter logic [15:0] VEC_RST = 16'hFFFC,
   parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rdy,
   input  logic        i_sync,
   input  logic        i_brk,
   input  logic        i_nmi_n,
   input  logic        i_irq_n,
   input  logic [7:0]  i_pstatus,
   output logic        o_inject,
   output logic        o_seq_active,
   output logic        o_push,
   output logic        o_push_wr,
   output logic [1:0]  o_push_src,
   output logic        o_push_b,
   output logic        o_vec_rd,
   output logic [15:0] o_vec_addr,
   output logic        o_set_i,
   output logic        o_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_T2, S_PCH, S_PCL, S_P, S_VECL, S_VECH
   } state_t;

   typedef enum logic [1:0] {
      K_RST, K_NMI, K_IRQ, K_BRK
   } kind_t;

   state_t      state, state_nxt;
   kind_t       kind, kind_nxt;
   logic        nmi_s1, nmi_s2, irq_s1, irq_s2;
   logic        nmi_pend, nmi_pend_nxt, nmi_fall, nmi_take, nmi_clr;
   logic        irq_req, take_int, vec_latch;
   logic [15:0] vec_base, vec_sel;
   logic        unused_pstatus;

   assign unused_pstatus = ^{i_pstatus[7:3], i_pstatus[1:0]};

   // Pin synchronizers run regardless of i_rdy so no edge is missed while frozen
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         nmi_s1 <= 1'b1;
         nmi_s2 <= 1'b1;
         irq_s1 <= 1'b1;
         irq_s2 <= 1'b1;
      end else begin
         nmi_s1 <= i_nmi_n;
         nmi_s2 <= nmi_s1;
         irq_s1 <= i_irq_n;
         irq_s2 <= irq_s1;
      end
   end

   assign nmi_fall  = nmi_s2 & ~nmi_s1;
   assign irq_req   = ~irq_s2 & ~i_pstatus[2];
   assign take_int  = nmi_pend | irq_req;
   assign vec_latch = (state == S_P) & i_rdy;

   always_comb begin
      nmi_take = 1'b0;
      vec_sel  = VEC_IRQ;
      if (kind == K_RST) begin
         vec_sel = VEC_RST;
`ifdef INT_NMI_HIJACK_EN
      end else if (nmi_pend || nmi_fall) begin
`else
      end else if (kind == K_NMI) begin
`endif
         vec_sel  = VEC_NMI;
         nmi_take = 1'b1;
      end
   end

   // A fresh edge consumed by this vector must not re-arm; an edge on top of a pending one still wins
   assign nmi_clr      = vec_latch & nmi_take;
   assign nmi_pend_nxt = (nmi_fall & ~(nmi_clr & ~nmi_pend)) | (nmi_pend & ~nmi_clr);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         nmi_pend <= 1'b0;
         vec_base <= 16'h0000;
      end else begin
         nmi_pend <= nmi_pend_nxt;
         if (vec_latch)
            vec_base <= vec_sel;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_T2;
         kind  <= K_RST;
      end else begin
         state <= state_nxt;
         kind  <= kind_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      kind_nxt  = kind;
      if (i_rdy) begin
         case (state)
            S_IDLE: begin
               if (i_sync) begin
                  if (take_int) begin
                     state_nxt = S_T2;
                     kind_nxt  = nmi_pend ? K_NMI : K_IRQ;
                  end else if (i_brk) begin
                     state_nxt = S_T2;
                     kind_nxt  = K_BRK;
                  end
               end
            end
            S_T2:    state_nxt = S_PCH;
            S_PCH:   state_nxt = S_PCL;
            S_PCL:   state_nxt = S_P;
            S_P:     state_nxt = S_VECL;
            S_VECL:  state_nxt = S_VECH;
            S_VECH:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_inject     = (state == S_IDLE) & i_sync & i_rdy & take_int;
      o_seq_active = (state != S_IDLE);
      o_push       = 1'b0;
      o_push_src   = 2'd0;
      o_push_b     = 1'b0;
      o_vec_rd     = 1'b0;
      o_vec_addr   = 16'h0000;
      o_set_i      = 1'b0;
      o_done       = 1'b0;
      case (state)
         S_PCH: o_push = 1'b1;
         S_PCL: begin
            o_push     = 1'b1;
            o_push_src = 2'd1;
         end
         S_P: begin
            o_push     = 1'b1;
            o_push_src = 2'd2;
            o_push_b   = (kind == K_BRK);
         end
         S_VECL: begin
            o_vec_rd   = 1'b1;
            o_vec_addr = vec_base;
         end
         S_VECH: begin
            o_vec_rd   = 1'b1;
            o_vec_addr = vec_base + 16'd1;
            o_set_i    = 1'b1;
            o_done     = 1'b1;
         end
         default: ;
      endcase
      o_push_wr = o_push & (kind != K_RST);
   end

endmodule
